// File: rtl/issue_queue_age.sv
// Age-ordered issue queue: holds up to DEPTH renamed instructions, tracks
// per-source readiness from a multi-port wakeup broadcast, and offers the
// oldest fully-ready entry to execution over a valid/ready handshake.
module issue_queue_age #(
  parameter int DEPTH      = 4,
  parameter int OPC_W      = 7,
  parameter int REG_W      = 5,
  parameter int WAKE_PORTS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          disp_valid,
  output logic                          disp_ready,
  input  logic [OPC_W-1:0]              disp_opcode,
  input  logic [REG_W-1:0]              disp_src1,
  input  logic [REG_W-1:0]              disp_src2,
  input  logic [REG_W-1:0]              disp_dest,
  input  logic                          disp_src1_ready,
  input  logic                          disp_src2_ready,
  input  logic [WAKE_PORTS-1:0]         wakeup_valid,
  input  logic [WAKE_PORTS*REG_W-1:0]   wakeup_dest,
  input  logic                          flush,
  output logic [DEPTH-1:0]              request_mask,
  output logic                          issue_valid,
  input  logic                          issue_ready,
  output logic [OPC_W-1:0]              issue_opcode,
  output logic [REG_W-1:0]              issue_src1,
  output logic [REG_W-1:0]              issue_src2,
  output logic [REG_W-1:0]              issue_dest,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Control state (reset) and per-entry payload (no reset)
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;   // older[i][j]: i older than j
  logic [CNT_W-1:0]            count_q, count_d;
  logic [DEPTH-1:0]            rdy1_q, rdy1_d;
  logic [DEPTH-1:0]            rdy2_q, rdy2_d;
  logic [OPC_W-1:0]            opc_q  [DEPTH];
  logic [OPC_W-1:0]            opc_d  [DEPTH];
  logic [REG_W-1:0]            src1_q [DEPTH];
  logic [REG_W-1:0]            src1_d [DEPTH];
  logic [REG_W-1:0]            src2_q [DEPTH];
  logic [REG_W-1:0]            src2_d [DEPTH];
  logic [REG_W-1:0]            dest_q [DEPTH];
  logic [REG_W-1:0]            dest_d [DEPTH];

  logic [DEPTH-1:0] sel;
  logic [IDX_W-1:0] alloc_idx;
  logic             disp_fire;
  logic             iss_fire;

  // True when any valid broadcast channel carries the given tag
  function automatic logic wake_hit(input logic [REG_W-1:0]            tag,
                                    input logic [WAKE_PORTS-1:0]       wv,
                                    input logic [WAKE_PORTS*REG_W-1:0] wd);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WAKE_PORTS; k++) begin
      if (wv[k] && (wd[k*REG_W +: REG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  assign request_mask = valid_q & rdy1_q & rdy2_q;
  assign issue_valid  = (|request_mask) && !flush;
  assign disp_ready   = (count_q < DEPTH_C) && !flush;
  assign disp_fire    = disp_valid && disp_ready;
  assign iss_fire     = issue_valid && issue_ready;
  assign count        = count_q;

  // Oldest-ready select: a requester wins unless an older requester exists
  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = request_mask[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (request_mask[j] && older_q[j][i]) sel[i] = 1'b0;
      end
    end
  end

  // Lowest-index free slot from registered state (a slot freed this cycle is not reused)
  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = IDX_W'(i);
    end
  end

  // One-hot mux of the selected entry; all zeros when nothing is offered
  always_comb begin
    issue_opcode = '0;
    issue_src1   = '0;
    issue_src2   = '0;
    issue_dest   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i] && issue_valid) begin
        issue_opcode = issue_opcode | opc_q[i];
        issue_src1   = issue_src1   | src1_q[i];
        issue_src2   = issue_src2   | src2_q[i];
        issue_dest   = issue_dest   | dest_q[i];
      end
    end
  end

  // Next state: wakeup, issue release, allocation with bypass, flush
  always_comb begin
    valid_d = valid_q;
    older_d = older_q;
    count_d = count_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    opc_d   = opc_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    dest_d  = dest_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        if (wake_hit(src1_q[i], wakeup_valid, wakeup_dest)) rdy1_d[i] = 1'b1;
        if (wake_hit(src2_q[i], wakeup_valid, wakeup_dest)) rdy2_d[i] = 1'b1;
      end
    end

    if (iss_fire) valid_d = valid_d & ~sel;

    if (disp_fire) begin
      valid_d[alloc_idx] = 1'b1;
      opc_d[alloc_idx]   = disp_opcode;
      src1_d[alloc_idx]  = disp_src1;
      src2_d[alloc_idx]  = disp_src2;
      dest_d[alloc_idx]  = disp_dest;
      rdy1_d[alloc_idx]  = disp_src1_ready || wake_hit(disp_src1, wakeup_valid, wakeup_dest);
      rdy2_d[alloc_idx]  = disp_src2_ready || wake_hit(disp_src2, wakeup_valid, wakeup_dest);
      older_d[alloc_idx] = '0;
      // Every surviving entry is older than the newcomer
      for (int j = 0; j < DEPTH; j++) begin
        if (valid_q[j] && !(iss_fire && sel[j])) older_d[j][alloc_idx] = 1'b1;
      end
    end

    case ({disp_fire, iss_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      older_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      older_q <= older_d;
      count_q <= count_d;
    end
  end

  // Payload and readiness registers; meaningful only while the entry is valid
  always_ff @(posedge clk) begin
    rdy1_q <= rdy1_d;
    rdy2_q <= rdy2_d;
    opc_q  <= opc_d;
    src1_q <= src1_d;
    src2_q <= src2_d;
    dest_q <= dest_d;
  end

endmodule
